present_iter_core: RTL and testbench

PRESENT_ITER_CORE -- requirements
Module: present_iter_core

---
 rtl/present_iter_core.sv | 217 +++++++++++++++++++++
 tb/tb_present_iter_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_iter_core.sv
// present_iter_core: iterative PRESENT-style block cipher core with one round per clock.
// The cipher state, key register and round counter advance once per cycle. The result is
// held in DONE until the consumer takes it.
// Optional feature macro: PRESENT_DECRYPT_EN. When it is defined, the core also supports
// decryption: the KEYFWD state, the inverse S-box, the inverse pLayer and the inverse key
// update are compiled in. When it is undefined, every request is an encryption.
module present_iter_core #(
    parameter int BLOCK_W = 16,
    parameter int KEY_W   = 20,
    parameter int ROUNDS  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [BLOCK_W-1:0] in_text,
    input  logic [KEY_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_text
);

    localparam int         ROT      = 13 % KEY_W;
    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef PRESENT_DECRYPT_EN
        KEYFWD,
`endif
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t             state_q;
    logic [4:0]         cnt_q;
    logic [BLOCK_W-1:0] data_q;
    logic [KEY_W-1:0]   key_q;
    logic               outValid_q;
    logic [BLOCK_W-1:0] outText_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Destination of bit i under pLayer; the top bit maps onto itself.
    function automatic int pDest(input int i);
        return (i == BLOCK_W - 1) ? i : (i * BLOCK_W / 4) % (BLOCK_W - 1);
    endfunction

    // Forward key update: rotate left, substitute the top nibble, then mix in the round index.
    function automatic logic [KEY_W-1:0] keyForward(input logic [KEY_W-1:0] k, input logic [4:0] r);
        logic [KEY_W-1:0] t;
        t = (k << ROT) | (k >> (KEY_W - ROT));
        t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
        t[4:0] = t[4:0] ^ r;
        return t;
    endfunction

    logic [4:0]         cntInc;
    logic [BLOCK_W-1:0] roundKey;
    logic [BLOCK_W-1:0] encMix;
    logic [BLOCK_W-1:0] encSub;
    logic [BLOCK_W-1:0] encPerm;
    logic [KEY_W-1:0]   keyFwd_d;

    assign cntInc   = cnt_q + 5'd1;
    assign roundKey = key_q[KEY_W-1 -: BLOCK_W];
    assign encMix   = data_q ^ roundKey;
    assign keyFwd_d = keyForward(key_q, cntInc);

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sub
        assign encSub[4*n +: 4] = sbox(encMix[4*n +: 4]);
    end

    for (genvar i = 0; i < BLOCK_W; i++) begin : g_perm
        assign encPerm[pDest(i)] = encSub[i];
    end

`ifdef PRESENT_DECRYPT_EN
    function automatic logic [3:0] invSbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'hC: y = 4'h0;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'hB: y = 4'h3;
            4'h9: y = 4'h4;  4'h0: y = 4'h5;  4'hA: y = 4'h6;  4'hD: y = 4'h7;
            4'h3: y = 4'h8;  4'hE: y = 4'h9;  4'hF: y = 4'hA;  4'h8: y = 4'hB;
            4'h4: y = 4'hC;  4'h7: y = 4'hD;  4'h1: y = 4'hE;  default: y = 4'hF;
        endcase
        return y;
    endfunction

    // Undoes keyForward for round r: remove the index, undo the S-box, then rotate right.
    function automatic logic [KEY_W-1:0] keyBackward(input logic [KEY_W-1:0] k, input logic [4:0] r);
        logic [KEY_W-1:0] t;
        t = k;
        t[4:0] = t[4:0] ^ r;
        t[KEY_W-1 -: 4] = invSbox(t[KEY_W-1 -: 4]);
        t = (t >> ROT) | (t << (KEY_W - ROT));
        return t;
    endfunction

    logic               mode_q;
    logic [KEY_W-1:0]   keyInv_d;
    logic [BLOCK_W-1:0] decInvPerm;
    logic [BLOCK_W-1:0] decSub;
    logic [BLOCK_W-1:0] decNext;

    // In decrypt ROUND the counter holds r+1, so keyBackward yields k_r for this round.
    assign keyInv_d = keyBackward(key_q, cnt_q);
    assign decNext  = decSub ^ keyInv_d[KEY_W-1 -: BLOCK_W];

    for (genvar i = 0; i < BLOCK_W; i++) begin : g_iperm
        assign decInvPerm[i] = data_q[pDest(i)];
    end

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_isub
        assign decSub[4*n +: 4] = invSbox(decInvPerm[4*n +: 4]);
    end
`else
    logic unusedMode;
    assign unusedMode = in_mode;
`endif

    // Requests are accepted only while idle and out of reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = outValid_q;
    assign out_text  = outText_q;

    // Control FSM plus datapath registers: one round, key step or whitening per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            data_q     <= '0;
            key_q      <= '0;
            outValid_q <= 1'b0;
            outText_q  <= '0;
`ifdef PRESENT_DECRYPT_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_text;
                        key_q  <= in_key;
                        cnt_q  <= 5'd0;
`ifdef PRESENT_DECRYPT_EN
                        mode_q  <= in_mode;
                        state_q <= in_mode ? KEYFWD : ROUND;
`else
                        state_q <= ROUND;
`endif
                    end
                end
`ifdef PRESENT_DECRYPT_EN
                KEYFWD: begin
                    key_q <= keyFwd_d;
                    cnt_q <= cntInc;
                    if (cnt_q == LAST_RND) state_q <= FINAL;
                end
`endif
                ROUND: begin
`ifdef PRESENT_DECRYPT_EN
                    if (mode_q) begin
                        data_q <= decNext;
                        key_q  <= keyInv_d;
                        cnt_q  <= cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            outText_q  <= decNext;
                        end
                    end else
`endif
                    begin
                        data_q <= encPerm;
                        key_q  <= keyFwd_d;
                        cnt_q  <= cntInc;
                        if (cnt_q == LAST_RND) state_q <= FINAL;
                    end
                end
                FINAL: begin
                    data_q <= data_q ^ roundKey;
`ifdef PRESENT_DECRYPT_EN
                    if (mode_q) begin
                        state_q <= ROUND;
                    end else
`endif
                    begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                        outText_q  <= data_q ^ roundKey;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        outText_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_iter_core.sv
// tb_present_iter_core: two cores (ROUNDS=1 and ROUNDS=7) checked against a bit-level
// arithmetic model of the cipher. Decrypt expectations follow PRESENT_DECRYPT_EN.
module tb_present_iter_core;

    typedef longint unsigned u64;

    localparam int BW = 16;
    localparam int KW = 20;
    localparam int R0 = 1;
    localparam int R1 = 7;

`ifdef PRESENT_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid[2];
    logic          inReady[2];
    logic          inMode[2];
    logic [BW-1:0] inText[2];
    logic [KW-1:0] inKey[2];
    logic          outValid[2];
    logic          outReady[2];
    logic [BW-1:0] outText[2];

    int total = 0;
    int bad   = 0;
    int sboxTab[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    always #5 clk = ~clk;

    present_iter_core #(.BLOCK_W(BW), .KEY_W(KW), .ROUNDS(R0)) dutA (
        .clk(clk), .rst(rst),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_mode(inMode[0]),
        .in_text(inText[0]), .in_key(inKey[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_text(outText[0])
    );

    present_iter_core #(.BLOCK_W(BW), .KEY_W(KW), .ROUNDS(R1)) dutB (
        .clk(clk), .rst(rst),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_mode(inMode[1]),
        .in_text(inText[1]), .in_key(inKey[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_text(outText[1])
    );

    // Round key r: the 20-bit key register stepped r times, keeping its top 16 bits.
    function automatic u64 keyAt(input u64 key, input int r);
        u64 k;
        k = key;
        for (int i = 1; i <= r; i++) begin
            k = (k % 128) * 8192 + k / 128;
            k = u64'(sboxTab[int'(k / 65536)]) * 65536 + k % 65536;
            k = k ^ u64'(i);
        end
        return k / 16;
    endfunction

    function automatic u64 subLayer(input u64 s, input bit inv);
        u64 o;
        int v;
        int w;
        o = 0;
        for (int n = 0; n < BW / 4; n++) begin
            v = int'((s >> (4 * n)) % 16);
            w = sboxTab[v];
            if (inv) begin
                for (int j = 0; j < 16; j++) if (sboxTab[j] == v) w = j;
            end
            o = o + u64'(w) * (u64'(1) << (4 * n));
        end
        return o;
    endfunction

    function automatic int bitDest(input int i);
        return (i == BW - 1) ? i : (i * BW / 4) % (BW - 1);
    endfunction

    function automatic u64 permLayer(input u64 s, input bit inv);
        u64 o;
        o = 0;
        for (int i = 0; i < BW; i++) begin
            if (!inv && ((s >> i) & 1) != 0) o = o | (u64'(1) << bitDest(i));
            if (inv && ((s >> bitDest(i)) & 1) != 0) o = o | (u64'(1) << i);
        end
        return o;
    endfunction

    function automatic u64 modelEnc(input u64 pt, input u64 key, input int rounds);
        u64 s;
        s = pt;
        for (int r = 1; r <= rounds; r++) s = permLayer(subLayer(s ^ keyAt(key, r - 1), 0), 0);
        return s ^ keyAt(key, rounds);
    endfunction

    function automatic u64 modelDec(input u64 ct, input u64 key, input int rounds);
        u64 s;
        s = ct ^ keyAt(key, rounds);
        for (int r = rounds - 1; r >= 0; r--) s = subLayer(permLayer(s, 1), 1) ^ keyAt(key, r);
        return s;
    endfunction

    function automatic u64 modelRun(input bit mode, input u64 text, input u64 key, input int rounds);
        return (mode && DEC_EN) ? modelDec(text, key, rounds) : modelEnc(text, key, rounds);
    endfunction

    function automatic int modelLat(input bit mode, input int rounds);
        return (mode && DEC_EN) ? 2 * rounds + 1 : rounds + 1;
    endfunction

    task automatic checkOutput(input string tag, input u64 observed, input u64 expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request at a negedge and leaves once it has been accepted.
    task automatic startOp(input int sel, input bit mode, input u64 text, input u64 key);
        @(negedge clk);
        checkOutput("ready_before_req", u64'(inReady[sel]), 1);
        inValid[sel] = 1'b1;
        inMode[sel]  = mode;
        inText[sel]  = text[BW-1:0];
        inKey[sel]   = key[KW-1:0];
        @(posedge clk);
        @(negedge clk);
        inValid[sel] = 1'b0;
        inMode[sel]  = ~mode;
        inText[sel]  = BW'($urandom);
        inKey[sel]   = KW'($urandom);
    endtask

    // Counts cycles after acceptance until out_valid, bounded; 0 means it never came.
    task automatic waitResult(input int sel, output int lat);
        int nonZero;
        lat = 0;
        nonZero = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (outValid[sel]) begin
                lat = c;
                break;
            end
            if (outText[sel] != '0) nonZero++;
        end
        checkOutput("text_zero_while_busy", u64'(nonZero), 0);
    endtask

    task automatic consumeResult(input int sel);
        outReady[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady[sel] = 1'b0;
        checkOutput("valid_low_after_take", u64'(outValid[sel]), 0);
        checkOutput("text_zero_after_take", u64'(outText[sel]), 0);
        checkOutput("ready_after_take", u64'(inReady[sel]), 1);
    endtask

    task automatic applyStimulus(input string tag, input int sel, input bit mode, input u64 text,
                                 input u64 key, input u64 expText, input int expLat, output u64 got);
        int lat;
        startOp(sel, mode, text, key);
        waitResult(sel, lat);
        got = u64'(outText[sel]);
        checkOutput({tag, "_text"}, got, expText);
        checkOutput({tag, "_lat"}, u64'(lat), u64'(expLat));
        consumeResult(sel);
    endtask

    initial begin
        u64 got;
        u64 ct;
        u64 txt;
        u64 key;
        bit mode;
        int sel;
        int lat;
        int seen;

        for (int i = 0; i < 2; i++) begin
            inValid[i] = 1'b0; inMode[i] = 1'b0; inText[i] = '0; inKey[i] = '0; outReady[i] = 1'b0;
        end

        // Reset state, then ready straight after release.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_ready", u64'(inReady[i]), 0);
            checkOutput("reset_valid", u64'(outValid[i]), 0);
            checkOutput("reset_text", u64'(outText[i]), 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset_a", u64'(inReady[0]), 1);
        checkOutput("ready_after_reset_b", u64'(inReady[1]), 1);

        // ROUNDS=1 known vectors.
        applyStimulus("r1_enc_zero", 0, 1'b0, 0, 0, 64'h3F00, 2, got);
`ifdef PRESENT_DECRYPT_EN
        applyStimulus("r1_dec_3f00", 0, 1'b1, 64'h3F00, 0, 64'h0000, 3, got);
`else
        applyStimulus("r1_mode1_encrypts", 0, 1'b1, 0, 0, 64'h3F00, 2, got);
`endif

        // Default rounds, encrypt then decrypt the result.
        applyStimulus("r7_enc_1234", 1, 1'b0, 64'h1234, 64'hABCDE,
                      modelEnc(64'h1234, 64'hABCDE, R1), 8, ct);
`ifdef PRESENT_DECRYPT_EN
        applyStimulus("r7_dec_back", 1, 1'b1, ct, 64'hABCDE, 64'h1234, 15, got);
`endif

        // Hold the result for 10 cycles while a request arrives that must be dropped.
        startOp(1, 1'b0, 64'h5A5A, 64'h13579);
        waitResult(1, lat);
        checkOutput("stall_lat", u64'(lat), 8);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                inValid[1] = 1'b1; inMode[1] = 1'b0; inText[1] = 16'hFFFF; inKey[1] = 20'h0F0F0;
            end
            if (c == 4) inValid[1] = 1'b0;
            checkOutput("stall_text", u64'(outText[1]), modelEnc(64'h5A5A, 64'h13579, R1));
            checkOutput("stall_ready", u64'(inReady[1]), 0);
            @(negedge clk);
        end
        consumeResult(1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (outValid[1]) seen++;
        end
        checkOutput("dropped_req_no_output", u64'(seen), 0);

        // Reset during an operation aborts it.
        startOp(1, 1'b1, 64'hBEEF, 64'h2468A);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_ready_low", u64'(inReady[1]), 0);
        checkOutput("midreset_valid_low", u64'(outValid[1]), 0);
        rst = 1'b0;
        #1;
        checkOutput("midreset_ready_after", u64'(inReady[1]), 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (outValid[1]) seen++;
        end
        checkOutput("midreset_no_output", u64'(seen), 0);
        applyStimulus("post_reset_enc", 1, 1'b0, 64'h0F1E, 64'h77777,
                      modelEnc(64'h0F1E, 64'h77777, R1), 8, got);

        // Randomised requests on either core against the model.
        for (int i = 0; i < 24; i++) begin
            sel  = int'($urandom_range(0, 1));
            mode = 1'($urandom);
            txt  = u64'($urandom) % 65536;
            key  = u64'($urandom) % 1048576;
            applyStimulus($sformatf("rand%0d", i), sel, mode, txt, key,
                          modelRun(mode, txt, key, sel == 1 ? R1 : R0),
                          modelLat(mode, sel == 1 ? R1 : R0), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
